// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared types and constants for the bit-serial subtractor:
//               FSM state enum, default operand width and the bit-counter
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    // Controller states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Default operand / result width
    localparam int c_default_width = 8;

    // Bit counter must be able to hold the value WIDTH
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/serial_sub_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_if
// Description : Start/done handshake and operand/result bus of serial_sub.
//               The borrow-in signal exists only when SERIAL_SUB_BIN_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_sub_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = c_default_width
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_BIN_EN
    logic             bin;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

`ifdef SERIAL_SUB_BIN_EN
    modport master (output start, a, b, bin, input busy, done, diff, borrow);
    modport slave  (input start, a, b, bin, output busy, done, diff, borrow);
`else
    modport master (output start, a, b, input busy, done, diff, borrow);
    modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif

endinterface : serial_sub_if
`default_nettype wire

// File: rtl/serial_sub_fs.sv
`default_nettype none
// ============================================================================
// Module      : fs
// Description : Single-bit full subtractor, purely combinational.
//               df = a - b - c (mod 2), br = borrow out.
// Revision    : 1.0 - initial release
// ============================================================================
module fs (
    input  wire logic a,
    input  wire logic b,
    input  wire logic c,
    output logic      df,
    output logic      br
);

    // Difference bit and borrow-out of a - b - c
    always_comb begin
        df = a ^ b ^ c;
        br = (~a & (b | c)) | (b & c);
    end

endmodule : fs
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub
// Description : Bit-serial WIDTH-bit unsigned subtractor (a - b [- bin]),
//               LSB first, one fs cell, borrow carried in a flop between
//               cycles. Result after WIDTH+1 cycles, start/done handshake.
//               Optional feature macro: SERIAL_SUB_BIN_EN (borrow-in port).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    serial_sub_if.slave bus
);

    localparam int             c_cw    = cnt_width(WIDTH);
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    localparam logic [1:0] c_idle = IDLE;
    localparam logic [1:0] c_run  = RUN;
    localparam logic [1:0] c_done = DONE;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sd;
    logic [c_cw-1:0]  r_cnt;
    logic             r_brw;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_done;
    logic             r_busy;
    logic             w_df;
    logic             w_br;
    logic             w_bin;

`ifdef SERIAL_SUB_BIN_EN
    assign w_bin = bus.bin;
`else
    assign w_bin = 1'b0;
`endif

    fs u_fs (
        .a  (r_sa[0]),
        .b  (r_sb[0]),
        .c  (r_brw),
        .df (w_df),
        .br (w_br)
    );

    // Next-state decode; start only counts in IDLE, so requests are not queued
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (bus.start) w_next_state = c_run;
            c_run:   if (r_cnt == c_last) w_next_state = c_done;
            c_done:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // State register plus registered busy/done flags (busy spans RUN and the result cycle)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != c_idle) || (r_state == c_done);
            r_done  <= (r_state == c_done);
        end
    end

    // Operand capture, serial shift/borrow datapath and result latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_sd     <= '0;
            r_cnt    <= '0;
            r_brw    <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.start) begin
                        r_sa  <= bus.a;
                        r_sb  <= bus.b;
                        r_cnt <= '0;
                        r_brw <= w_bin;
                    end
                end
                c_run: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_sd  <= {w_df, r_sd[WIDTH-1:1]};
                    r_brw <= w_br;
                    r_cnt <= r_cnt + c_one;
                end
                c_done: begin
                    r_diff   <= r_sd;
                    r_borrow <= r_brw;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.diff   = r_diff;
    assign bus.borrow = r_borrow;

endmodule : serial_sub
`default_nettype wire

// File: doc/serial_sub.md
# serial_sub

Bit-serial WIDTH-bit subtractor built around the team's single-bit full subtractor `fs`. It computes `a - b` one bit per clock, LSB first, and carries the borrow between cycles in a flip-flop. It sits directly upstream of the parallel result consumers. It trades WIDTH+1 cycles of latency for one `fs` instance plus shift registers, and uses a start/done handshake.

## Interface

Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a subtraction; sampled only in IDLE.
- `a`  in  WIDTH: minuend; captured on an accepted `start`.
- `b`  in  WIDTH: subtrahend; captured on an accepted `start`.
- `bin`  in  1: borrow-in; captured with the operands. Present only with `SERIAL_SUB_BIN_EN`.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: one-cycle pulse when `diff`/`borrow` become valid.
- `diff`  out  WIDTH: `(a - b - bin) mod 2^WIDTH`.
- `borrow`  out  1: final borrow-out. High iff `a < b + bin` (unsigned).

## Operation

- States:
  - IDLE: `busy`=0. `start`=1 loads `a`→`sa`, `b`→`sb`, clears bit counter, sets borrow flop to `bin` (0 without the macro), then goes to RUN.
  - RUN: each cycle `fs` takes `sa[0]`, `sb[0]` and the borrow flop. `sa`/`sb` shift right. The `fs` difference shifts into `sd[WIDTH-1]` and `sd` shifts right. The `fs` borrow updates the borrow flop. Counter increments. After the WIDTH-th bit, go to DONE.
  - DONE: `done`=1 for exactly this cycle. `diff`←`sd`, `borrow`←borrow flop. Then go to IDLE.
- `diff`/`borrow` are registered outputs. They hold their value until the next DONE, so they survive new starts until overwritten.
- `start` in RUN or DONE is ignored. Requests are not queued.
- Arithmetic is unsigned modulo 2^WIDTH. Signed interpretation is the consumer's concern; `borrow` is not an overflow flag.
- Counter width is `$clog2(WIDTH+1)`. Terminal count is WIDTH-1 in RUN. No wrap-around beyond that.

## Timing

- Reset (asynchronous assert, synchronous-safe deassert by the system): state=IDLE; `busy`=0, `done`=0, `diff`=0, `borrow`=0; shift registers, counter and borrow flop cleared.
- Reset mid-operation aborts immediately. No `done` is produced for the aborted request.
- `start` accepted at edge k:
  - `busy` is high from k through k+WIDTH+1.
  - RUN occupies edges k+1..k+WIDTH.
  - `done`=1 and outputs are valid after edge k+WIDTH+1.
  - Latency start→done is WIDTH+1 cycles.
- Earliest next accepted `start` is at edge k+WIDTH+2, giving a throughput of one result per WIDTH+2 cycles.
- `a`/`b`/`bin` need to be stable only at the accepting edge.

## Configuration

- `SERIAL_SUB_BIN_EN` defined:
  - `bin` port exists and seeds the borrow flop at start.
  - This allows multi-word chaining by feeding the previous word's `borrow` into `bin`.
- Undefined:
  - No `bin` port; the initial borrow is the constant 0.
  - All other behaviour is identical.

## Structure

- Package `serial_sub_pkg`:
  - state enum `{IDLE, RUN, DONE}`, 2-bit encoding.
  - default WIDTH constant.
  - counter-width helper function.
- Sub-module: one instance of the existing `fs`, port order `(a, b, c, df, br)`, combinational. All sequential logic lives in `serial_sub`.

## Test plan

- WIDTH=8, a=0x05, b=0x03, start pulse → `done` 9 cycles later; `diff`=0x02, `borrow`=0, `busy` high 10 cycles.
- a=0x03, b=0x05 → `diff`=0xFE, `borrow`=1. Also a=0x00, b=0x00 → `diff`=0x00, `borrow`=0. Also a=0xFF, b=0x01 → `diff`=0xFE, `borrow`=0.
- Issue a start with a=0x10, b=0x01, then at cycle 3 of RUN assert `start` with a=0xAA, b=0x55 → second request ignored; `diff`=0x0F; exactly one `done`.
- Assert `rst_n`=0 at cycle 4 of RUN → outputs 0 immediately, state IDLE, no `done`. A new start of a=0x09, b=0x04 then gives `diff`=0x05.
- With `SERIAL_SUB_BIN_EN`, a=0x05, b=0x03, bin=1 → `diff`=0x01, `borrow`=0. a=0x00, b=0x00, bin=1 → `diff`=0xFF, `borrow`=1.
- Exhaustive WIDTH=4 sweep of all 256 (a,b) pairs, back-to-back starts → every result matches the reference model; `done` spacing is exactly 6 cycles.
